// File: rtl/rs_issue_sel.sv
// rs_issue_sel: reservation-station slot array with operand wakeup and
// round-robin single-issue selection.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   alloc_wr[NUM_SLOTS]         one-hot slot write from the allocator
//   alloc_src{1,2}_tag/_rdy     source tags and "already available" flags
//   cdb_valid, cdb_tag          result broadcast (wakes matching sources)
//   flush                       synchronous clear of every slot
//   issue_valid/slot/idx        slot offered to the functional unit
//   issue_ready                 functional unit accepts the offer
//   slot_busy, rs_empty         occupancy back to the allocator

// Per-slot state: occupancy, two source ready bits and their tags.
module rs_slot #(
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 alloc_en,
  input  logic [TAG_WIDTH-1:0] alloc_src1_tag,
  input  logic [TAG_WIDTH-1:0] alloc_src2_tag,
  input  logic                 alloc_src1_rdy,
  input  logic                 alloc_src2_rdy,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic                 clr,
  output logic                 busy,
  output logic                 eligible
);
  logic                 rdy1, rdy2;
  logic [TAG_WIDTH-1:0] tag1, tag2;

  assign eligible = busy & rdy1 & rdy2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      rdy1 <= 1'b0;
      rdy2 <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else if (flush || clr) begin
      busy <= 1'b0;
      rdy1 <= 1'b0;
      rdy2 <= 1'b0;
    end else if (alloc_en && !busy) begin
      // A same-cycle broadcast of the source tag must not be missed.
      busy <= 1'b1;
      tag1 <= alloc_src1_tag;
      tag2 <= alloc_src2_tag;
      rdy1 <= alloc_src1_rdy | (cdb_valid && cdb_tag == alloc_src1_tag);
      rdy2 <= alloc_src2_rdy | (cdb_valid && cdb_tag == alloc_src2_tag);
    end else if (busy && cdb_valid) begin
      if (cdb_tag == tag1) rdy1 <= 1'b1;
      if (cdb_tag == tag2) rdy2 <= 1'b1;
    end
  end
endmodule

module rs_issue_sel #(
  parameter int NUM_SLOTS = 8,
  parameter int TAG_WIDTH = 6,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] alloc_wr,
  input  logic [TAG_WIDTH-1:0] alloc_src1_tag,
  input  logic [TAG_WIDTH-1:0] alloc_src2_tag,
  input  logic                 alloc_src1_rdy,
  input  logic                 alloc_src2_rdy,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic                 flush,
  output logic                 issue_valid,
  output logic [NUM_SLOTS-1:0] issue_slot,
  output logic [IDX_W-1:0]     issue_idx,
  input  logic                 issue_ready,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic                 rs_empty
);
  localparam logic [IDX_W:0] NS = (IDX_W+1)'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] elig, clr;
  logic                 alloc_oh, hs, rr_found;
  logic [IDX_W-1:0]     rr_ptr, rr_idx, hold_idx;
  logic                 hold_vld;

  // Multi-hot writes are dropped entirely rather than partially applied.
  assign alloc_oh = (alloc_wr != '0) && ((alloc_wr & (alloc_wr - NUM_SLOTS'(1))) == '0);
  assign hs       = issue_valid & issue_ready;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign clr[i] = hs & issue_slot[i];
    rs_slot #(.TAG_WIDTH(TAG_WIDTH)) u_slot (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .alloc_en       (alloc_oh & alloc_wr[i]),
      .alloc_src1_tag (alloc_src1_tag),
      .alloc_src2_tag (alloc_src2_tag),
      .alloc_src1_rdy (alloc_src1_rdy),
      .alloc_src2_rdy (alloc_src2_rdy),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .clr            (clr[i]),
      .busy           (slot_busy[i]),
      .eligible       (elig[i])
    );
  end

  // First eligible slot at or after rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;
    rr_found = 1'b0;
    rr_idx   = '0;
    sum      = '0;
    j        = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= NS) sum = sum - NS;
      j = sum[IDX_W-1:0];
      if (!rr_found && elig[j]) begin
        rr_found = 1'b1;
        rr_idx   = j;
      end
    end
  end

  // A held grant keeps its slot eligible, so hold_vld alone implies valid.
  assign issue_valid = hold_vld | rr_found;
  assign issue_idx   = hold_vld ? hold_idx : (rr_found ? rr_idx : '0);
  assign issue_slot  = issue_valid ? (NUM_SLOTS'(1) << issue_idx) : '0;
  assign rs_empty    = ~|slot_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_idx <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      hold_vld <= 1'b0;
      rr_ptr   <= '0;
    end else if (hs) begin
      hold_vld <= 1'b0;
      rr_ptr   <= (issue_idx == IDX_W'(NUM_SLOTS-1)) ? '0 : issue_idx + IDX_W'(1);
    end else if (issue_valid) begin
      hold_vld <= 1'b1;
      hold_idx <= issue_idx;
    end
  end
endmodule

// File: doc/rs_issue_sel.md
RS_ISSUE_SEL -- requirements
Module: rs_issue_sel

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, number of reservation-station slots; 2 to 32.
REQ-002 SHALL have parameter TAG_WIDTH, default 6, width of a producer tag.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alloc_wr  input  NUM_SLOTS  one-hot slot write enable from the allocator.
REQ-006 SHALL have ports alloc_src1_tag, alloc_src2_tag  input  TAG_WIDTH  source tags of the allocated instruction.
REQ-007 SHALL have ports alloc_src1_rdy, alloc_src2_rdy  input  1  source operand already available.
REQ-008 SHALL have ports cdb_valid  input  1 and cdb_tag  input  TAG_WIDTH  result broadcast.
REQ-009 SHALL have port flush  input  1  synchronous clear of all slots.
REQ-010 SHALL have port issue_valid  output  1  an instruction is offered to the functional unit.
REQ-011 SHALL have ports issue_slot  output  NUM_SLOTS (one-hot) and issue_idx  output  clog2(NUM_SLOTS) (binary), both naming the offered slot.
REQ-012 SHALL have port issue_ready  input  1  functional unit accepts.
REQ-013 SHALL have ports slot_busy  output  NUM_SLOTS (per-slot occupied, feeds the allocator) and rs_empty  output  1.

Function
REQ-014 SHALL keep per-slot state: busy, rdy1, rdy2, tag1 and tag2; SHALL keep a round-robin pointer rr_ptr and a grant-hold register.
REQ-015 Allocation: alloc_wr[i]=1 with busy[i]=0 SHALL set busy[i]=1, store both tags, and set rdyN = alloc_srcN_rdy OR (cdb_valid AND cdb_tag==alloc_srcN_tag).
REQ-016 SHALL ignore alloc_wr to a busy slot; a non-one-hot, non-zero alloc_wr SHALL write no slot.
REQ-017 Wakeup: for every busy slot with rdyN=0 and tagN==cdb_tag while cdb_valid=1, rdyN SHALL be 1 the next cycle; all matching slots wake in the same cycle.
REQ-018 A slot SHALL be eligible when busy, rdy1 and rdy2 are all 1 in registered state; wakeup and allocation therefore make a slot eligible one cycle later.
REQ-019 Selection: with no grant held, the offered slot SHALL be the first eligible index at or after rr_ptr, wrapping from NUM_SLOTS-1 to 0.
REQ-020 issue_valid SHALL be 1 iff a grant is held or any slot is eligible; issue_slot and issue_idx SHALL be 0 when issue_valid=0.
REQ-021 Hold: while issue_valid=1 and issue_ready=0, issue_idx SHALL remain unchanged on following cycles, even if another slot becomes eligible.
REQ-022 Handshake (issue_valid AND issue_ready at the edge) SHALL clear busy, rdy1 and rdy2 of the offered slot and release the hold.
REQ-023 On handshake, rr_ptr SHALL become (issue_idx+1) mod NUM_SLOTS; rr_ptr SHALL be otherwise unchanged.
REQ-024 A freed slot SHALL show slot_busy=0 the cycle after the handshake; it SHALL NOT be reallocated in the handshake cycle.
REQ-025 Back-to-back issue SHALL sustain one handshake per cycle while eligible slots exist.
REQ-026 rs_empty SHALL equal NOR of busy.
REQ-027 flush SHALL clear all busy and rdy bits, release the hold and set rr_ptr=0 at the next edge.
REQ-028 flush SHALL take priority over allocation, wakeup and handshake in the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately clear busy, rdy, hold and rr_ptr; during reset issue_valid=0, issue_slot=0, issue_idx=0, slot_busy=0 and rs_empty=1.
REQ-030 Reset asserted mid-handshake SHALL discard the offered instruction with no partial state retained.

Verification
REQ-031 Reset, then alloc_wr=0x01 with both rdy=1 -> next cycle issue_valid=1 and issue_idx=0; issue_ready=1 -> next cycle slot_busy=0x00 and rr_ptr=1.
REQ-032 Alloc slot 2 with src1_tag=5, rdy1=0, rdy2=1; cdb_valid with cdb_tag=5 two cycles later -> issue_valid rises exactly one cycle after the CDB cycle, issue_idx=2.
REQ-033 Alloc slot 3 with src1_tag=9, rdy1=0 and cdb_tag=9 valid in the same cycle -> issue_valid=1 and issue_idx=3 the next cycle.
REQ-034 Slots 0, 1 and 3 eligible, rr_ptr=0, issue_ready held 1 -> issue_idx sequence 0, 1, 3, then rr_ptr=4; with rr_ptr=7 and slots 0 and 6 eligible -> order 0, then 6.
REQ-035 rr_ptr=2, slot 5 offered, issue_ready=0 for 3 cycles while slot 2 becomes eligible -> issue_idx stays 5 until the handshake, then 2 is offered.
REQ-036 4 slots busy and a grant held, then flush=1 with same-cycle alloc_wr=0x80 and issue_ready=1 -> next cycle slot_busy=0x00, issue_valid=0, rs_empty=1 and rr_ptr=0.
